// File: rtl/shift_reg_univ.sv
// shift_reg_univ: parametrised universal shift register.
// Supports hold, right shift, left shift and parallel load, with optional
// rotate. Also counts shifts since the last load and emits a one-cycle
// done pulse when a full word has been shifted.
module shift_reg_univ #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             rotate,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             done
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_RIGHT = 2'b01,
        MODE_LEFT  = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    // Saturation value of the counter, and the value one shift before it,
    // which is the only count from which a shift may raise done.
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] q_q,    q_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             done_q, done_d;

    mode_e            op;
    logic             in_right;
    logic             in_left;
    logic             is_shift;

    // Pick the bit entering each end: the bit falling off the far end when
    // rotating, otherwise the matching serial input.
    always_comb begin
        op       = mode_e'(mode);
        in_right = rotate ? q_q[0]       : sin_r;
        in_left  = rotate ? q_q[WIDTH-1] : sin_l;
    end

    // Next-state for the data word, the shift counter and the done pulse.
    // done defaults low so it can only ever last a single cycle.
    always_comb begin
        q_d      = q_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        is_shift = 1'b0;

        if (en) begin
            case (op)
                MODE_HOLD: begin
                    q_d = q_q;
                end
                MODE_RIGHT: begin
                    q_d      = {in_right, q_q[WIDTH-1:1]};
                    is_shift = 1'b1;
                end
                MODE_LEFT: begin
                    q_d      = {q_q[WIDTH-2:0], in_left};
                    is_shift = 1'b1;
                end
                MODE_LOAD: begin
                    q_d   = d;
                    cnt_d = '0;
                end
                default: begin
                    q_d = q_q;
                end
            endcase

            if (is_shift) begin
                if (cnt_q < CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
                done_d = (cnt_q == CNT_LAST);
            end
        end
    end

    // State register with synchronous active-high reset overriding enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q    <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    // Serial outputs come straight from the end bits of the register.
    always_comb begin
        q         = q_q;
        shift_cnt = cnt_q;
        done      = done_q;
        sout_r    = q_q[0];
        sout_l    = q_q[WIDTH-1];
    end

endmodule

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal shift register built from synchronous D flip-flop stages, generalising the fixed 4-bit serial shifter to any width. Supports hold, right shift, left shift and parallel load, with optional rotate. A shift counter tracks shifts since the last load and pulses `done` once a full word has been shifted. It sits between parallel datapath logic and serial links: parallel-to-serial, serial-to-parallel or barrel-style rotation.

## Interface
- `WIDTH`, default 4: register width in bits; legal range WIDTH ≥ 2.
- `CNT_W`, default $clog2(WIDTH+1): width of `shift_cnt`. Derived; do not override.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; clock `clk`.
- `en`  in  1  clock enable; 0 freezes `q` and `shift_cnt`.
- `mode`  in  2  operation select:
  - 00 = hold
  - 01 = shift right (toward LSB)
  - 10 = shift left (toward MSB)
  - 11 = parallel load
- `rotate`  in  1  when 1, the bit shifted out re-enters at the opposite end instead of the serial input.
- `sin_r`  in  1  serial input entering the MSB on a right shift.
- `sin_l`  in  1  serial input entering the LSB on a left shift.
- `d`  in  WIDTH  parallel load data.
- `q`  out  WIDTH  register contents.
- `sout_r`  out  1  equals `q[0]`; next bit lost on a right shift.
- `sout_l`  out  1  equals `q[WIDTH-1]`; next bit lost on a left shift.
- `shift_cnt`  out  CNT_W  number of shifts since the last load or reset; saturates at WIDTH.
- `done`  out  1  registered one-cycle pulse on the shift that brings `shift_cnt` to WIDTH.

## Operation
- **Reset** (highest priority, overrides `en`):
  - `q` = 0, `shift_cnt` = 0, `done` = 0.
- **en = 0**: `q` and `shift_cnt` hold; `done` = 0 on the next edge.
- **en = 1, mode 00**: `q` and `shift_cnt` hold; `done` = 0.
- **en = 1, mode 01**:
  - `q` ← {`in`, `q[WIDTH-1:1]`}, where `in` = `rotate` ? `q[0]` : `sin_r`.
- **en = 1, mode 10**:
  - `q` ← {`q[WIDTH-2:0]`, `in`}, where `in` = `rotate` ? `q[WIDTH-1]` : `sin_l`.
- **en = 1, mode 11**:
  - `q` ← `d`, `shift_cnt` ← 0, `done` ← 0.
  - `rotate`, `sin_r` and `sin_l` are ignored.
- **Shift counting** (mode 01 and mode 10, with or without rotate):
  - If `shift_cnt` < WIDTH, `shift_cnt` increments.
  - If `shift_cnt` = WIDTH, `shift_cnt` stays at WIDTH.
  - `done` ← 1 only when `shift_cnt` was WIDTH-1 before the edge; otherwise `done` ← 0.
- **Mixed directions**: left and right shifts count identically; no net-displacement tracking.
- **Saturation**: further shifts after saturation never re-assert `done`. Only a load or reset re-arms it.
- **Combinational outputs**: `sout_r` and `sout_l` are driven directly from `q`.
- **Unused inputs**: `sin_r`, `sin_l` and `d` have no effect except in their own mode.

## Timing
- Latency:
  - `q` and `shift_cnt` reflect an operation 1 cycle after the sampling edge.
  - `sout_*` follow `q` with zero additional latency.
  - `done` is high for exactly one clock period, in the same cycle that `shift_cnt` first reads WIDTH.
- **Reset mid-sequence**: a reset during a shift run clears everything on that edge. A pending `done` is never emitted.
- **Load on the completing cycle**: if a load occurs on the cycle that would have completed the count, the load wins and `done` stays 0.
- **Stalls**: `en` may drop between shifts; the count resumes without loss, and `done` fires on the WIDTH-th enabled shift.
- **Throughput**: one shift per cycle; a load and its first shift may be on consecutive cycles.

## Test plan
- **Reset**: assert `reset` with `en`=1, `mode`=11, `d`=4'hF → after the edge, `q`=0, `shift_cnt`=0, `done`=0.
- **Right-shift drain** (WIDTH=4): load 4'b1011, then 4 right shifts with `sin_r`=0.
  - `q` sequence: 0101, 0010, 0001, 0000.
  - `sout_r` sequence before each shift: 1, 1, 0, 1.
  - `done`=1 only in the cycle `shift_cnt`=4.
- **Left rotate**: load 4'b1011, 4 left shifts with `rotate`=1.
  - `q` sequence: 0111, 1110, 1101, 1011.
  - `done` pulses once; a 5th shift leaves `shift_cnt`=4 and `done`=0.
- **Enable stall**: load 4'b1000, shift right twice, hold `en`=0 for 3 cycles, then shift right twice with `sin_r`=1.
  - `q` is frozen at 0010 during the stall.
  - Final `q`=1100, with `done` on the final shift.
- **Reset mid-run**: load 4'b0110, shift 3 times, then assert `reset` on the 4th shift cycle.
  - `q`=0, `shift_cnt`=0, and `done` is never asserted.
- **Width generality** (WIDTH=8): load 8'hA5, 8 left shifts with `sin_l`=1.
  - `q`=8'hFF and `shift_cnt`=8.
  - `done` pulses exactly once, and the observed `sout_l` stream is 1,0,1,0,0,1,0,1.
